// File: rtl/dog_round_ctrl_pkg.sv
// Shared types and constants for the dog sprite sequencer and its fire logic.
package dog_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WALK,
    ST_SNIFF,
    ST_JUMP,
    ST_FALL,
    ST_HIDDEN,
    ST_REACT_HIT,
    ST_REACT_MISS
  } state_e;

  // Sprite frame indices into AssetsDogs_rom
  localparam logic [4:0] FR_WALK0  = 5'd0;
  localparam logic [4:0] FR_SNIFF0 = 5'd4;
  localparam logic [4:0] FR_JUMP   = 5'd6;
  localparam logic [4:0] FR_FALL   = 5'd7;
  localparam logic [4:0] FR_LAUGH0 = 5'd8;
  localparam logic [4:0] FR_HOLD   = 5'd10;

  localparam logic [7:0] FIRE_CODE = 8'h02;

  localparam int TICK_W = 7;

endpackage

// File: rtl/dog_round_ctrl_if.sv
// Input/output bundle between the sequencer and the mouse/VGA/color_mapper side.
interface dog_round_if;

  logic              frame_tick;
  logic              start;
  logic signed [7:0] MouseButtons;
  logic              target_hit;

  logic [9:0]        Dog_X;
  logic [9:0]        Dog_Y;
  logic [4:0]        Frame;
  logic              resetSignal;
  logic [1:0]        shots_used;
  logic [3:0]        hit_count;
  logic [2:0]        round_num;
  logic              game_done;

  modport master (
    output frame_tick, start, MouseButtons, target_hit,
    input  Dog_X, Dog_Y, Frame, resetSignal, shots_used, hit_count, round_num, game_done
  );

  modport slave (
    input  frame_tick, start, MouseButtons, target_hit,
    output Dog_X, Dog_Y, Frame, resetSignal, shots_used, hit_count, round_num, game_done
  );

endinterface

// File: rtl/dog_round_ctrl_fire_edge_detect.sv
// Registered match against a button code followed by a rising-edge pulse.
module fire_edge_detect
  import dog_game_pkg::*;
#(
  parameter int             W    = 8,
  parameter logic [W-1:0]   CODE = W'(FIRE_CODE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_i,
  output logic         fire_o
);

  logic lvl_q;
  logic dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      lvl_q <= (data_i == CODE);
      dly_q <= lvl_q;
    end
  end

  // A level already high when a consumer starts listening never produces a pulse.
  assign fire_o = lvl_q & ~dly_q;

endmodule

// File: rtl/dog_round_ctrl.sv
// Dog sprite / round sequencer: intro animation, shooting phase, reactions, scoring.
module dog_round_ctrl
  import dog_game_pkg::*;
#(
  parameter int WALK_Y      = 320,
  parameter int WALK_STEP   = 2,
  parameter int SNIFF_X     = 200,
  parameter int ANIM_DIV    = 8,
  parameter int SNIFF_TICKS = 60,
  parameter int JUMP_TOP_Y  = 220,
  parameter int JUMP_STEP   = 4,
  parameter int HIDE_Y      = 340,
  parameter int REACT_Y     = 300,
  parameter int REACT_TICKS = 90,
  parameter int NUM_ROUNDS  = 5,
  parameter int MAX_SHOTS   = 3
) (
  input  logic      vga_clk,
  input  logic      Reset,
  dog_round_if.slave bus
);

  localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [9:0]        WALK_Y_V     = 10'(WALK_Y);
  localparam logic [9:0]        WALK_STEP_V  = 10'(WALK_STEP);
  localparam logic [9:0]        SNIFF_X_V    = 10'(SNIFF_X);
  localparam logic [9:0]        JUMP_TOP_V   = 10'(JUMP_TOP_Y);
  localparam logic [9:0]        JUMP_STEP_V  = 10'(JUMP_STEP);
  localparam logic [9:0]        HIDE_Y_V     = 10'(HIDE_Y);
  localparam logic [9:0]        REACT_Y_V    = 10'(REACT_Y);
  localparam logic [ANIM_W-1:0] ANIM_LAST    = ANIM_W'(ANIM_DIV - 1);
  localparam logic [TICK_W-1:0] SNIFF_LAST   = TICK_W'(SNIFF_TICKS - 1);
  localparam logic [TICK_W-1:0] REACT_LAST   = TICK_W'(REACT_TICKS - 1);
  localparam logic [2:0]        ROUND_LAST   = 3'(NUM_ROUNDS - 1);
  localparam logic [1:0]        MAX_SHOTS_V  = 2'(MAX_SHOTS);

  state_e              state_q, state_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic [4:0]          frame_q, frame_d;
  logic                hide_q, hide_d;
  logic [1:0]          shots_q, shots_d;
  logic [3:0]          hits_q, hits_d;
  logic [2:0]          round_q, round_d;
  logic                done_q, done_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [ANIM_W-1:0]   anim_q, anim_d;

  logic                fire;
  logic                anim_wrap;
  logic [ANIM_W-1:0]   anim_nxt;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [4:0] toggle_pair(input logic [4:0] cur, input logic [4:0] base);
    return (cur == base) ? base + 5'd1 : base;
  endfunction

  fire_edge_detect #(
    .W    (8),
    .CODE (FIRE_CODE)
  ) u_fire (
    .clk    (vga_clk),
    .rst    (Reset),
    .data_i (bus.MouseButtons),
    .fire_o (fire)
  );

  assign anim_wrap = (anim_q == ANIM_LAST);
  assign anim_nxt  = anim_wrap ? '0 : anim_q + ANIM_W'(1);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    hide_d  = hide_q;
    shots_d = shots_q;
    hits_d  = hits_q;
    round_d = round_q;
    done_d  = 1'b0;
    tick_d  = tick_q;
    anim_d  = anim_q;

    unique case (state_q)
      ST_IDLE: begin
        hide_d = 1'b1;
        if (bus.start) begin
          state_d = ST_WALK;
          x_d     = '0;
          y_d     = WALK_Y_V;
          frame_d = FR_WALK0;
          hide_d  = 1'b0;
          hits_d  = '0;
          round_d = '0;
          shots_d = '0;
          tick_d  = '0;
          anim_d  = '0;
        end
      end

      ST_WALK: begin
        if (bus.frame_tick) begin
          x_d    = x_q + WALK_STEP_V;
          anim_d = anim_nxt;
          if (anim_wrap) begin
            frame_d = (frame_q == FR_WALK0 + 5'd3) ? FR_WALK0 : frame_q + 5'd1;
          end
          if (x_d >= SNIFF_X_V) begin
            state_d = ST_SNIFF;
            frame_d = FR_SNIFF0;
            tick_d  = '0;
            anim_d  = '0;
          end
        end
      end

      ST_SNIFF: begin
        if (bus.frame_tick) begin
          anim_d = anim_nxt;
          if (anim_wrap) begin
            frame_d = toggle_pair(frame_q, FR_SNIFF0);
          end
          if (tick_q == SNIFF_LAST) begin
            state_d = ST_JUMP;
            frame_d = FR_JUMP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      ST_JUMP: begin
        if (bus.frame_tick) begin
          y_d = y_q - JUMP_STEP_V;
          if (y_d <= JUMP_TOP_V) begin
            state_d = ST_FALL;
            frame_d = FR_FALL;
          end
        end
      end

      ST_FALL: begin
        if (bus.frame_tick) begin
          y_d = y_q + JUMP_STEP_V;
          if (y_d >= HIDE_Y_V) begin
            state_d = ST_HIDDEN;
            hide_d  = 1'b1;
            shots_d = '0;
          end
        end
      end

      // frame_tick is deliberately ignored here; only fire drives this state.
      ST_HIDDEN: begin
        if (fire && (shots_q < MAX_SHOTS_V)) begin
          shots_d = shots_q + 2'd1;
          if (bus.target_hit) begin
            hits_d  = sat_inc4(hits_q);
            state_d = ST_REACT_HIT;
            frame_d = FR_HOLD;
          end else if (shots_d == MAX_SHOTS_V) begin
            state_d = ST_REACT_MISS;
            frame_d = FR_LAUGH0;
          end
          if (bus.target_hit || (shots_d == MAX_SHOTS_V)) begin
            y_d    = REACT_Y_V;
            hide_d = 1'b0;
            tick_d = '0;
            anim_d = '0;
          end
        end
      end

      ST_REACT_HIT, ST_REACT_MISS: begin
        if (bus.frame_tick) begin
          if (state_q == ST_REACT_MISS) begin
            anim_d = anim_nxt;
            if (anim_wrap) begin
              frame_d = toggle_pair(frame_q, FR_LAUGH0);
            end
          end
          if (tick_q == REACT_LAST) begin
            hide_d = 1'b1;
            if (round_q == ROUND_LAST) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              round_d = round_q + 3'd1;
              shots_d = '0;
              state_d = ST_HIDDEN;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= WALK_Y_V;
      frame_q <= FR_WALK0;
      hide_q  <= 1'b1;
      shots_q <= '0;
      hits_q  <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
      tick_q  <= '0;
      anim_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      hide_q  <= hide_d;
      shots_q <= shots_d;
      hits_q  <= hits_d;
      round_q <= round_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      anim_q  <= anim_d;
    end
  end

  assign bus.Dog_X       = x_q;
  assign bus.Dog_Y       = y_q;
  assign bus.Frame       = frame_q;
  assign bus.resetSignal = hide_q;
  assign bus.shots_used  = shots_q;
  assign bus.hit_count   = hits_q;
  assign bus.round_num   = round_q;
  assign bus.game_done   = done_q;

endmodule

// File: tb/tb_dog_round_ctrl.sv
// Self-checking bench for dog_round_ctrl: intro table, shooting rounds, game end.
module tb_dog_round_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dog_round_if bus();

  dog_round_ctrl dut (
    .vga_clk (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] fr;
    logic       hide;
    logic [1:0] shots;
    logic [3:0] hits;
    logic [2:0] rnd;
    logic       gd;
  } exp_t;

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] fr;
    logic       hide;
  } iv_t;

  exp_t sb_q[$];
  iv_t  itab[$];
  int   total = 0;
  int   bad   = 0;
  int   gd_cnt = 0;

  always @(negedge clk) if (bus.game_done === 1'b1) gd_cnt++;

  function automatic exp_t mk(string nm, int x, int y, int fr, int hide,
                              int shots, int hits, int rnd, int gd);
    exp_t e;
    e.name = nm; e.x = 10'(x); e.y = 10'(y); e.fr = 5'(fr); e.hide = 1'(hide);
    e.shots = 2'(shots); e.hits = 4'(hits); e.rnd = 3'(rnd); e.gd = 1'(gd);
    return e;
  endfunction

  task automatic sb_push(input exp_t e);
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: no expected record queued");
      return;
    end
    e = sb_q.pop_front();
    if ({bus.Dog_X, bus.Dog_Y, bus.Frame, bus.resetSignal, bus.shots_used,
         bus.hit_count, bus.round_num, bus.game_done} !==
        {e.x, e.y, e.fr, e.hide, e.shots, e.hits, e.rnd, e.gd}) begin
      bad++;
      $display("FAIL %s: got X=%0d Y=%0d Fr=%0d hide=%0b shots=%0d hits=%0d rnd=%0d gd=%0b, want X=%0d Y=%0d Fr=%0d hide=%0b shots=%0d hits=%0d rnd=%0d gd=%0b",
               e.name, bus.Dog_X, bus.Dog_Y, bus.Frame, bus.resetSignal, bus.shots_used,
               bus.hit_count, bus.round_num, bus.game_done,
               e.x, e.y, e.fr, e.hide, e.shots, e.hits, e.rnd, e.gd);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic do_tick();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic click();
    @(negedge clk) bus.MouseButtons = 8'sh02;
    @(negedge clk);
    @(negedge clk) bus.MouseButtons = 8'sh00;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_ticks;
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.MouseButtons = 8'sh00;
    bus.target_hit = 1'b0;

    // Intro checkpoints, tick count measured from start.
    itab.push_back('{1,   10'd2,   10'd320, 5'd0, 1'b0});
    itab.push_back('{8,   10'd16,  10'd320, 5'd1, 1'b0});
    itab.push_back('{16,  10'd32,  10'd320, 5'd2, 1'b0});
    itab.push_back('{31,  10'd62,  10'd320, 5'd3, 1'b0});
    itab.push_back('{32,  10'd64,  10'd320, 5'd0, 1'b0});
    itab.push_back('{99,  10'd198, 10'd320, 5'd0, 1'b0});
    itab.push_back('{100, 10'd200, 10'd320, 5'd4, 1'b0});
    itab.push_back('{108, 10'd200, 10'd320, 5'd5, 1'b0});
    itab.push_back('{116, 10'd200, 10'd320, 5'd4, 1'b0});
    itab.push_back('{159, 10'd200, 10'd320, 5'd5, 1'b0});
    itab.push_back('{160, 10'd200, 10'd320, 5'd6, 1'b0});
    itab.push_back('{161, 10'd200, 10'd316, 5'd6, 1'b0});
    itab.push_back('{184, 10'd200, 10'd224, 5'd6, 1'b0});
    itab.push_back('{185, 10'd200, 10'd220, 5'd7, 1'b0});
    itab.push_back('{214, 10'd200, 10'd336, 5'd7, 1'b0});
    itab.push_back('{215, 10'd200, 10'd340, 5'd7, 1'b1});

    repeat (3) @(negedge clk);
    sb_push(mk("reset_hold", 0, 320, 0, 1, 0, 0, 0, 0));
    sb_check();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    sb_push(mk("idle", 0, 320, 0, 1, 0, 0, 0, 0));
    sb_check();

    // Async reset in the middle of the walk
    sb_push(mk("start", 0, 320, 0, 0, 0, 0, 0, 0));
    pulse_start();
    sb_check();
    sb_push(mk("walk_x40", 40, 320, 2, 0, 0, 0, 0, 0));
    ticks(20);
    sb_check();
    @(negedge clk) rst = 1'b1;
    #1;
    sb_push(mk("async_reset", 0, 320, 0, 1, 0, 0, 0, 0));
    sb_check();
    @(negedge clk) rst = 1'b0;

    // Full intro from a fresh start
    pulse_start();
    done_ticks = 0;
    foreach (itab[i]) begin
      sb_push(mk($sformatf("intro_t%0d", itab[i].n), int'(itab[i].x), int'(itab[i].y),
                 int'(itab[i].fr), int'(itab[i].hide), 0, 0, 0, 0));
      while (done_ticks < itab[i].n) begin
        do_tick();
        done_ticks++;
      end
      sb_check();
    end

    // Round 0: three misses
    bus.target_hit = 1'b0;
    sb_push(mk("miss_shot1", 200, 340, 7, 1, 1, 0, 0, 0)); click(); sb_check();
    sb_push(mk("miss_shot2", 200, 340, 7, 1, 2, 0, 0, 0)); click(); sb_check();
    sb_push(mk("miss_shot3", 200, 300, 8, 0, 3, 0, 0, 0)); click(); sb_check();
    sb_push(mk("miss_click4", 200, 300, 8, 0, 3, 0, 0, 0)); click(); sb_check();
    sb_push(mk("laugh_t8", 200, 300, 9, 0, 3, 0, 0, 0)); ticks(8); sb_check();
    sb_push(mk("laugh_t89", 200, 300, 9, 0, 3, 0, 0, 0)); ticks(81); sb_check();
    // Hold the button across the return to HIDDEN
    @(negedge clk) bus.MouseButtons = 8'sh02;
    sb_push(mk("round1_entry", 200, 300, 9, 1, 0, 0, 1, 0)); do_tick(); sb_check();

    // Round 1: held button never fires; then a hit
    repeat (4) @(negedge clk);
    sb_push(mk("held_no_shot", 200, 300, 9, 1, 0, 0, 1, 0)); sb_check();
    @(negedge clk) bus.MouseButtons = 8'sh00;
    repeat (3) @(negedge clk);
    bus.target_hit = 1'b1;
    sb_push(mk("hit_round1", 200, 300, 10, 0, 1, 1, 1, 0)); click(); sb_check();
    sb_push(mk("hit_no_extra", 200, 300, 10, 0, 1, 1, 1, 0)); click(); sb_check();
    sb_push(mk("round2_entry", 200, 300, 10, 1, 0, 1, 2, 0)); ticks(90); sb_check();

    // Round 2: start ignored, then fire coinciding with frame_tick
    sb_push(mk("start_in_hidden", 200, 300, 10, 1, 0, 1, 2, 0));
    pulse_start();
    @(negedge clk);
    sb_check();
    @(negedge clk) bus.MouseButtons = 8'sh02;
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) begin bus.frame_tick = 1'b0; bus.MouseButtons = 8'sh00; end
    @(negedge clk);
    sb_push(mk("fire_with_tick", 200, 300, 10, 0, 1, 2, 2, 0)); sb_check();
    sb_push(mk("round3_entry", 200, 300, 10, 1, 0, 2, 3, 0)); ticks(90); sb_check();

    // Rounds 3 and 4 end the game
    sb_push(mk("hit_round3", 200, 300, 10, 0, 1, 3, 3, 0)); click(); sb_check();
    sb_push(mk("round4_entry", 200, 300, 10, 1, 0, 3, 4, 0)); ticks(90); sb_check();
    sb_push(mk("hit_round4", 200, 300, 10, 0, 1, 4, 4, 0)); click(); sb_check();
    ticks(89);
    check_int("no_done_before_end", gd_cnt, 0);
    sb_push(mk("game_done_pulse", 200, 300, 10, 1, 1, 4, 4, 1)); do_tick(); sb_check();
    @(negedge clk);
    sb_push(mk("after_done", 200, 300, 10, 1, 1, 4, 4, 0)); sb_check();
    repeat (3) @(negedge clk);
    check_int("done_pulse_count", gd_cnt, 1);
    sb_push(mk("restart_idle", 0, 320, 0, 0, 0, 0, 0, 0));
    pulse_start();
    sb_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
